spi_cmd_sequencer: RTL and testbench
====================================

Name: spi_cmd_sequencer

Overview:
Command sequencer between the SPI byte receiver and the configuration memory / ready-flag registers of the SNN chip. It parses each SS-framed transaction as an instruction byte, optional 16-bit address, then payload bytes. It issues burst writes with address auto-increment, serves burst reads back onto the byte transmitter, and sets the clk_div / input_spike / debug_config ready flags. It also flags illegal instructions and out-of-range addresses.

Parameters:
ADDR_W, 8, width of mem_addr.
MEM_DEPTH, 162, number of valid byte locations; legal addresses are 0..MEM_DEPTH-1.

Ports:
SCLK  input  1  SPI clock; all state updates on posedge.
RESET  input  1  asynchronous, active-high reset.
SS  input  1  slave select, active low; high = no transaction.
rx_data  input  8  byte from SPI receiver; valid when rx_valid=1.
rx_valid  input  1  one-SCLK-cycle pulse per received byte.
tx_data  output  8  byte the receiver shifts out on the next byte slot.
mem_addr  output  ADDR_W  memory address.
mem_wdata  output  8  memory write data.
mem_we  output  1  memory write strobe, one cycle per byte.
mem_rdata  input  8  combinational read data at mem_addr.
clk_div_ready  output  1  ready flag.
input_spike_ready  output  1  ready flag.
debug_config_ready  output  1  ready flag.
cmd_error  output  1  sticky error: illegal opcode or address out of range.
busy  output  1  high while state != IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal 16-bit address 0; opcode register 0.
- Opcodes: 0x01 WRITE, 0x02 READ, 0x03 SET_CLKDIV, 0x04 SET_SPIKE, 0x05 SET_DEBUG. Any other value is illegal.
- States: IDLE, ADDR_MSB, ADDR_LSB, WDATA, RDATA, FLAG, DRAIN.
- Transitions occur only on cycles with rx_valid=1 and SS=0, except the SS rule below.
- IDLE: the byte is latched as the opcode and cmd_error is cleared.
  - 0x01/0x02 -> ADDR_MSB.
  - 0x03..0x05 -> FLAG.
  - Illegal opcode -> set cmd_error, go to DRAIN.
- ADDR_MSB: latch addr[15:8] -> ADDR_LSB.
- ADDR_LSB: latch addr[7:0].
  - If the full 16-bit address >= MEM_DEPTH: set cmd_error, go to DRAIN.
  - Otherwise go to WDATA (WRITE) or RDATA (READ).
- WDATA, on each byte:
  - The next cycle has mem_we=1, mem_wdata=byte, mem_addr=current address.
  - The address then increments; MEM_DEPTH-1 wraps to 0.
  - The state stays WDATA.
- RDATA:
  - mem_addr = current address.
  - tx_data is registered from mem_rdata every cycle, so it holds the byte at the current address one cycle after each address change.
  - Each received byte (dummy) increments the address with the same wrap rule.
  - mem_we stays 0.
- FLAG: bit0 of the byte is written to the selected flag (1 sets, 0 clears) -> DRAIN.
- DRAIN: bytes are ignored; no writes.
- Outside RDATA, tx_data = {cmd_error, busy, debug_config_ready, input_spike_ready, clk_div_ready, 3'b000}.
- SS=1 sampled on any posedge SCLK:
  - State returns to IDLE and mem_we is forced to 0.
  - A write strobe already scheduled for that cycle is dropped.
  - Flags and cmd_error are retained.
- A transaction aborted mid-address performs no write.
- rx_valid while SS=1 is ignored.
- RESET asserted mid-transaction: immediate return to reset values, including the flags.
- mem_addr is the low ADDR_W bits of the 16-bit address; the range check uses all 16 bits.

Test Plan:
- Write burst: SS low, bytes 0x01,0x00,0x05,0xAA,0xBB,0xCC -> mem_we pulses at addr 5,6,7 with data AA,BB,CC; SS high -> busy=0.
- Wrap: 0x01,0x00,0xA1 (161), then 0x11,0x22 -> writes addr 161=0x11, addr 0=0x22, cmd_error=0.
- Read burst, memory preloaded 10=0x3C, 11=0x5A: bytes 0x02,0x00,0x0A, then dummies -> tx_data=0x3C, then 0x5A after the first dummy; no mem_we.
- Flags: 0x03,0x01 -> clk_div_ready=1. Then 0x05,0x01 -> debug_config_ready=1. Then 0x03,0x00 -> clk_div_ready=0; debug_config_ready stays 1.
- Errors: 0x7F -> cmd_error=1 and further bytes cause no writes. Then 0x01,0x00,0xA2 -> cmd_error=1, no writes. A new legal 0x04 clears cmd_error.
- Abort/reset: SS raised after 0x01,0x00 -> no mem_we, next byte treated as opcode. RESET pulsed mid-WDATA -> all outputs 0 immediately.

Source files
------------

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer
//
// Turns the byte stream of one SS-framed SPI transaction into actions on
// the configuration memory and the ready-flag registers. A transaction is
// made of an instruction byte, an optional 16-bit address and then payload
// bytes.
//   0x01 WRITE      : address, then a burst of data bytes (auto-increment)
//   0x02 READ       : address, then dummy bytes; memory bytes go to tx_data
//   0x03 SET_CLKDIV : one byte, bit0 -> clk_div_ready
//   0x04 SET_SPIKE  : one byte, bit0 -> input_spike_ready
//   0x05 SET_DEBUG  : one byte, bit0 -> debug_config_ready
// Illegal opcodes and addresses >= MEM_DEPTH raise the sticky cmd_error.
//
// Ports
//   SCLK, RESET         : SPI clock (posedge), async active-high reset
//   SS                  : slave select, active low
//   rx_data, rx_valid   : received byte and its one-cycle valid pulse
//   tx_data             : byte shifted out on the next byte slot
//   mem_addr/wdata/we   : memory write port and shared address
//   mem_rdata           : combinational memory read data at mem_addr
//   *_ready             : ready flags
//   cmd_error           : sticky command error
//   busy                : high while a transaction is being parsed

module spi_cmd_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 162
) (
  input  logic              SCLK,
  input  logic              RESET,
  input  logic              SS,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              clk_div_ready,
  output logic              input_spike_ready,
  output logic              debug_config_ready,
  output logic              cmd_error,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_MSB,
    ADDR_LSB,
    WDATA,
    RDATA,
    FLAG,
    DRAIN
  } state_t;

  localparam logic [7:0]  OP_WRITE   = 8'h01;
  localparam logic [7:0]  OP_READ    = 8'h02;
  localparam logic [7:0]  OP_CLKDIV  = 8'h03;
  localparam logic [7:0]  OP_SPIKE   = 8'h04;
  localparam logic [7:0]  OP_DEBUG   = 8'h05;
  localparam logic [15:0] DEPTH16    = 16'(MEM_DEPTH);
  localparam logic [15:0] LAST_ADDR  = 16'(MEM_DEPTH - 1);

  state_t            state, state_n;
  logic [7:0]        opcode, opcode_n;
  logic [15:0]       addr, addr_n;
  logic [15:0]       addr_inc;
  logic [15:0]       full_addr;
  logic [ADDR_W-1:0] wr_addr, wr_addr_n;
  logic [7:0]        tx_q;
  logic              we_n;
  logic [7:0]        wdata_n;
  logic              clk_n, spk_n, dbg_n, err_n;

  // Address auto-increment wraps from the last valid location back to 0.
  assign addr_inc  = (addr == LAST_ADDR) ? 16'd0 : addr + 16'd1;
  assign full_addr = {addr[15:8], rx_data};

  // State register.
  always_ff @(posedge SCLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath registers. tx_q samples the memory every cycle so that during
  // a read burst it follows the current address with one cycle of latency.
  always_ff @(posedge SCLK or posedge RESET) begin
    if (RESET) begin
      opcode             <= 8'h00;
      addr               <= 16'h0000;
      wr_addr            <= '0;
      tx_q               <= 8'h00;
      mem_we             <= 1'b0;
      mem_wdata          <= 8'h00;
      clk_div_ready      <= 1'b0;
      input_spike_ready  <= 1'b0;
      debug_config_ready <= 1'b0;
      cmd_error          <= 1'b0;
    end else begin
      opcode             <= opcode_n;
      addr               <= addr_n;
      wr_addr            <= wr_addr_n;
      tx_q               <= mem_rdata;
      mem_we             <= we_n;
      mem_wdata          <= wdata_n;
      clk_div_ready      <= clk_n;
      input_spike_ready  <= spk_n;
      debug_config_ready <= dbg_n;
      cmd_error          <= err_n;
    end
  end

  // Next-state and next-value logic. SS high always wins: the parser goes
  // back to IDLE and no write strobe is issued, but flags and cmd_error
  // are left untouched.
  always_comb begin
    state_n   = state;
    opcode_n  = opcode;
    addr_n    = addr;
    wr_addr_n = wr_addr;
    we_n      = 1'b0;
    wdata_n   = mem_wdata;
    clk_n     = clk_div_ready;
    spk_n     = input_spike_ready;
    dbg_n     = debug_config_ready;
    err_n     = cmd_error;

    if (SS) begin
      state_n = IDLE;
    end else if (rx_valid) begin
      case (state)
        IDLE: begin
          opcode_n = rx_data;
          err_n    = 1'b0;
          case (rx_data)
            OP_WRITE, OP_READ:             state_n = ADDR_MSB;
            OP_CLKDIV, OP_SPIKE, OP_DEBUG: state_n = FLAG;
            default: begin
              err_n   = 1'b1;
              state_n = DRAIN;
            end
          endcase
        end
        ADDR_MSB: begin
          addr_n[15:8] = rx_data;
          state_n      = ADDR_LSB;
        end
        ADDR_LSB: begin
          addr_n = full_addr;
          if (full_addr >= DEPTH16) begin
            err_n   = 1'b1;
            state_n = DRAIN;
          end else if (opcode == OP_WRITE) begin
            state_n = WDATA;
          end else begin
            state_n = RDATA;
          end
        end
        WDATA: begin
          // The write address is captured separately because addr moves
          // on in the same edge that schedules the strobe.
          we_n      = 1'b1;
          wdata_n   = rx_data;
          wr_addr_n = addr[ADDR_W-1:0];
          addr_n    = addr_inc;
        end
        RDATA: begin
          addr_n = addr_inc;
        end
        FLAG: begin
          case (opcode)
            OP_CLKDIV: clk_n = rx_data[0];
            OP_SPIKE:  spk_n = rx_data[0];
            OP_DEBUG:  dbg_n = rx_data[0];
            default:   ;
          endcase
          state_n = DRAIN;
        end
        DRAIN: begin
          state_n = DRAIN;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign mem_addr = mem_we ? wr_addr : addr[ADDR_W-1:0];
  assign tx_data  = (state == RDATA) ? tx_q
                  : {cmd_error, busy, debug_config_ready, input_spike_ready,
                     clk_div_ready, 3'b000};

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer
//
// Directed bench for spi_cmd_sequencer. A byte-position transaction model
// predicts flags, error, busy, tx_data and the exact write strobes; one
// negedge process compares the DUT against it every cycle. Literal checks
// after each scenario pin the model to hand-computed values.

module tb_spi_cmd_sequencer;

  logic       SCLK;
  logic       RESET;
  logic       SS;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       clk_div_ready;
  logic       input_spike_ready;
  logic       debug_config_ready;
  logic       cmd_error;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Bench-side configuration memory
  logic [7:0] mem [0:255];
  int         wrCount = 0;

  // Transaction model state
  int          mIdx    = 0;
  logic [7:0]  mOpc    = 8'h00;
  logic [15:0] mAddr   = 16'h0000;
  logic        mDead   = 1'b0;
  logic        mErr    = 1'b0;
  logic        mClk    = 1'b0;
  logic        mSpk    = 1'b0;
  logic        mDbg    = 1'b0;
  int          settle  = 0;
  logic [15:0] expWr [$];

  spi_cmd_sequencer #(.ADDR_W(8), .MEM_DEPTH(162)) dut (
    .SCLK               (SCLK),
    .RESET              (RESET),
    .SS                 (SS),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .tx_data            (tx_data),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_we             (mem_we),
    .mem_rdata          (mem_rdata),
    .clk_div_ready      (clk_div_ready),
    .input_spike_ready  (input_spike_ready),
    .debug_config_ready (debug_config_ready),
    .cmd_error          (cmd_error),
    .busy               (busy)
  );

  initial begin
    SCLK = 1'b0;
    forever #5 SCLK = ~SCLK;
  end

  assign mem_rdata = mem[mem_addr];

  // Memory write port of the environment
  always @(posedge SCLK) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] = mem_wdata;
      wrCount++;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what one received byte means, judged only by its position in
  // the transaction and the opcode seen first.
  task automatic modelByte(input logic [7:0] b);
    if (mIdx == 0) begin
      mOpc  = b;
      mErr  = !(b >= 8'h01 && b <= 8'h05);
      mDead = 1'b0;
    end else if (mOpc == 8'h01 || mOpc == 8'h02) begin
      if (mIdx == 1) begin
        mAddr[15:8] = b;
      end else if (mIdx == 2) begin
        mAddr[7:0] = b;
        if (mAddr >= 16'd162) begin
          mErr  = 1'b1;
          mDead = 1'b1;
        end else if (mOpc == 8'h02) begin
          settle = 1;
        end
      end else if (!mDead) begin
        if (mOpc == 8'h01) expWr.push_back({mAddr[7:0], b});
        else settle = 1;
        mAddr = (mAddr == 16'd161) ? 16'd0 : mAddr + 16'd1;
      end
    end else if (mOpc >= 8'h03 && mOpc <= 8'h05 && mIdx == 1) begin
      if (mOpc == 8'h03) mClk = b[0];
      if (mOpc == 8'h04) mSpk = b[0];
      if (mOpc == 8'h05) mDbg = b[0];
    end
    if (mIdx < 1000) mIdx++;
  endtask

  // Every-cycle comparison against the model
  always @(negedge SCLK) begin
    logic [15:0] w;
    logic        mBusy;
    logic        mRead;
    mBusy = (mIdx > 0);
    mRead = (mOpc == 8'h02) && (mIdx >= 3) && !mDead;
    checkOutput("busy", {15'd0, busy}, {15'd0, mBusy});
    checkOutput("cmd_error", {15'd0, cmd_error}, {15'd0, mErr});
    checkOutput("clk_div_ready", {15'd0, clk_div_ready}, {15'd0, mClk});
    checkOutput("input_spike_ready", {15'd0, input_spike_ready}, {15'd0, mSpk});
    checkOutput("debug_config_ready", {15'd0, debug_config_ready}, {15'd0, mDbg});
    if (expWr.size() > 0) begin
      w = expWr.pop_front();
      checkOutput("mem_we", {15'd0, mem_we}, 16'd1);
      checkOutput("mem_addr", {8'd0, mem_addr}, {8'd0, w[15:8]});
      checkOutput("mem_wdata", {8'd0, mem_wdata}, {8'd0, w[7:0]});
    end else begin
      checkOutput("mem_we", {15'd0, mem_we}, 16'd0);
    end
    if (mRead) begin
      if (settle > 0) settle--;
      else checkOutput("tx_data_read", {8'd0, tx_data}, {8'd0, mem[mAddr[7:0]]});
    end else begin
      checkOutput("tx_data_status", {8'd0, tx_data},
                  {8'd0, mErr, mBusy, mDbg, mSpk, mClk, 3'b000});
    end
  end

  // One byte on the receive interface, followed by idle SPI bit times
  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge SCLK);
    #1;
    rx_valid = 1'b0;
    modelByte(b);
    repeat (3) begin
      @(posedge SCLK);
      #1;
    end
  endtask

  task automatic startTxn();
    SS = 1'b0;
    @(posedge SCLK);
    #1;
  endtask

  task automatic endTxn();
    SS = 1'b1;
    @(posedge SCLK);
    #1;
    mIdx  = 0;
    mDead = 1'b0;
    repeat (2) begin
      @(posedge SCLK);
      #1;
    end
  endtask

  task automatic sendTxn(input logic [7:0] bytes [$]);
    startTxn();
    foreach (bytes[i]) applyStimulus(bytes[i]);
    endTxn();
  endtask

  initial begin
    int wrBefore;
    RESET    = 1'b1;
    SS       = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[10] = 8'h3C;
    mem[11] = 8'h5A;
    repeat (2) @(posedge SCLK);
    #1;
    checkOutput("reset_tx_data", {8'd0, tx_data}, 16'h0000);
    checkOutput("reset_busy", {15'd0, busy}, 16'd0);
    RESET = 1'b0;
    repeat (2) @(posedge SCLK);
    #1;

    $display("[TB] write burst");
    sendTxn('{8'h01, 8'h00, 8'h05, 8'hAA, 8'hBB, 8'hCC});
    checkOutput("wr_mem5", {8'd0, mem[5]}, 16'h00AA);
    checkOutput("wr_mem6", {8'd0, mem[6]}, 16'h00BB);
    checkOutput("wr_mem7", {8'd0, mem[7]}, 16'h00CC);
    checkOutput("wr_count", wrCount[15:0], 16'd3);
    checkOutput("wr_busy_after", {15'd0, busy}, 16'd0);

    $display("[TB] address wrap");
    sendTxn('{8'h01, 8'h00, 8'hA1, 8'h11, 8'h22});
    checkOutput("wrap_mem161", {8'd0, mem[161]}, 16'h0011);
    checkOutput("wrap_mem0", {8'd0, mem[0]}, 16'h0022);
    checkOutput("wrap_err", {15'd0, cmd_error}, 16'd0);

    $display("[TB] read burst");
    wrBefore = wrCount;
    startTxn();
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h0A);
    checkOutput("rd_first", {8'd0, tx_data}, 16'h003C);
    applyStimulus(8'h00);
    checkOutput("rd_second", {8'd0, tx_data}, 16'h005A);
    endTxn();
    checkOutput("rd_no_write", wrCount[15:0], wrBefore[15:0]);

    $display("[TB] flags");
    sendTxn('{8'h03, 8'h01});
    checkOutput("flag_clk_set", {15'd0, clk_div_ready}, 16'd1);
    sendTxn('{8'h05, 8'h01});
    checkOutput("flag_dbg_set", {15'd0, debug_config_ready}, 16'd1);
    sendTxn('{8'h03, 8'h00});
    checkOutput("flag_clk_clr", {15'd0, clk_div_ready}, 16'd0);
    checkOutput("flag_dbg_keep", {15'd0, debug_config_ready}, 16'd1);
    checkOutput("flag_status", {8'd0, tx_data}, 16'h0020);

    $display("[TB] errors");
    wrBefore = wrCount;
    sendTxn('{8'h7F, 8'h01, 8'h00, 8'h05, 8'hAA});
    checkOutput("err_opcode", {15'd0, cmd_error}, 16'd1);
    checkOutput("err_status", {8'd0, tx_data}, 16'h00A0);
    sendTxn('{8'h01, 8'h00, 8'hA2, 8'h55});
    checkOutput("err_range", {15'd0, cmd_error}, 16'd1);
    checkOutput("err_no_write", wrCount[15:0], wrBefore[15:0]);
    sendTxn('{8'h04, 8'h01});
    checkOutput("err_cleared", {15'd0, cmd_error}, 16'd0);
    checkOutput("err_spike_set", {15'd0, input_spike_ready}, 16'd1);

    $display("[TB] abort and reset");
    wrBefore = wrCount;
    sendTxn('{8'h01, 8'h00});
    checkOutput("abort_no_write", wrCount[15:0], wrBefore[15:0]);
    sendTxn('{8'h03, 8'h01});
    checkOutput("abort_new_opcode", {15'd0, clk_div_ready}, 16'd1);
    startTxn();
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h20);
    applyStimulus(8'h55);
    checkOutput("pre_reset_mem", {8'd0, mem[32]}, 16'h0055);
    RESET = 1'b1;
    #1;
    mIdx = 0; mOpc = 8'h00; mAddr = 16'h0000; mDead = 1'b0;
    mErr = 1'b0; mClk = 1'b0; mSpk = 1'b0; mDbg = 1'b0;
    settle = 0;
    expWr.delete();
    checkOutput("rst_busy", {15'd0, busy}, 16'd0);
    checkOutput("rst_tx_data", {8'd0, tx_data}, 16'h0000);
    checkOutput("rst_mem_we", {15'd0, mem_we}, 16'd0);
    checkOutput("rst_mem_addr", {8'd0, mem_addr}, 16'h0000);
    checkOutput("rst_mem_wdata", {8'd0, mem_wdata}, 16'h0000);
    checkOutput("rst_flags", {13'd0, clk_div_ready, input_spike_ready,
                debug_config_ready}, 16'd0);
    checkOutput("rst_cmd_error", {15'd0, cmd_error}, 16'd0);
    @(posedge SCLK);
    #1;
    RESET = 1'b0;
    endTxn();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
